// File: rtl/add_ovf_pkg.sv
// Shared defaults and helpers for the registered add/sub overflow detector.
package add_ovf_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int CNT_W_DEF = 8;

   // Saturating increment; callers widen their counter to 32 bits and pass its all-ones ceiling.
   function automatic logic [31:0] sat_inc(input logic [31:0] count, input logic [31:0] max_val);
      return (count == max_val) ? count : count + 32'd1;
   endfunction

endpackage

// File: rtl/add_overflow_detect_if.sv
// Operand/result bundle between a driver and the overflow detector.
interface add_overflow_detect_if #(
   parameter int WIDTH = add_ovf_pkg::WIDTH_DEF,
   parameter int CNT_W = add_ovf_pkg::CNT_W_DEF
);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             op_sub;
   logic             sticky_clr;
   logic             out_valid;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;
   logic             ovf_sticky;
   logic [CNT_W-1:0] ovf_count;

   modport master (
      output in_valid, a, b, op_sub, sticky_clr,
      input  out_valid, sum, carry, overflow, ovf_sticky, ovf_count
   );

   modport slave (
      input  in_valid, a, b, op_sub, sticky_clr,
      output out_valid, sum, carry, overflow, ovf_sticky, ovf_count
   );
endinterface

// File: rtl/ovf_sign_check.sv
// Signed-overflow rule from the operand and result sign bits.
module ovf_sign_check (
   input  logic a,
   input  logic b,
   input  logic z,
   output logic overflow
);
   // Operands of equal sign producing a result of the opposite sign.
   assign overflow = (a & b & ~z) | (~a & ~b & z);
endmodule

// File: rtl/add_overflow_detect.sv
// Registered two's-complement adder/subtractor with overflow flag, sticky bit and saturating event counter.
module add_overflow_detect
   import add_ovf_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic                 clk,
   input logic                 rst,
   add_overflow_detect_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] b_eff;
   logic             cin;
   logic [WIDTH:0]   total_n;
   logic             ovf_n;

   // Subtraction as a + ~b + 1 so carry-out reads as "no borrow".
   always_comb begin
      b_eff   = bus.op_sub ? ~bus.b : bus.b;
      cin     = bus.op_sub;
      total_n = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
   end

   ovf_sign_check u_sign_check (
      .a        (bus.a[WIDTH-1]),
      .b        (b_eff[WIDTH-1]),
      .z        (total_n[WIDTH-1]),
      .overflow (ovf_n)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.sum       <= '0;
         bus.carry     <= 1'b0;
         bus.overflow  <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.sum      <= total_n[WIDTH-1:0];
            bus.carry    <= total_n[WIDTH];
            bus.overflow <= ovf_n;
         end
      end
   end

   // Clear wins over a same-edge overflow event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.ovf_sticky <= 1'b0;
         bus.ovf_count  <= '0;
      end else if (bus.sticky_clr) begin
         bus.ovf_sticky <= 1'b0;
         bus.ovf_count  <= '0;
      end else if (bus.in_valid && ovf_n) begin
         bus.ovf_sticky <= 1'b1;
         bus.ovf_count  <= CNT_W'(sat_inc(32'(bus.ovf_count), 32'(CNT_MAX)));
      end
   end
endmodule

// File: tb/tb_add_overflow_detect.sv
// Directed self-checking bench for add_overflow_detect and its sign-check leaf.
module tb_add_overflow_detect;
   localparam int WIDTH = 8;
   localparam int CNT_W = 2;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic sc_a, sc_b, sc_z, sc_ovf;

   add_overflow_detect_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   add_overflow_detect #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   ovf_sign_check u_sc (
      .a        (sc_a),
      .b        (sc_b),
      .z        (sc_z),
      .overflow (sc_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic vld, input logic clr);
      @(negedge clk);
      bus.a          = a;
      bus.b          = b;
      bus.op_sub     = sub;
      bus.in_valid   = vld;
      bus.sticky_clr = clr;
      @(posedge clk);
      #1;
      bus.in_valid   = 1'b0;
      bus.sticky_clr = 1'b0;
   endtask

   task automatic chk_res(input string tag, input logic [7:0] s, input logic c, input logic o,
                          input logic v, input logic st, input logic [1:0] cnt);
      chk({tag, ".sum"},   32'(bus.sum),        32'(s));
      chk({tag, ".carry"}, 32'(bus.carry),      32'(c));
      chk({tag, ".ovf"},   32'(bus.overflow),   32'(o));
      chk({tag, ".vld"},   32'(bus.out_valid),  32'(v));
      chk({tag, ".stk"},   32'(bus.ovf_sticky), 32'(st));
      chk({tag, ".cnt"},   32'(bus.ovf_count),  32'(cnt));
   endtask

   initial begin
      logic [7:0] sc_table;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.in_valid   = 1'b0;
      bus.a          = '0;
      bus.b          = '0;
      bus.op_sub     = 1'b0;
      bus.sticky_clr = 1'b0;
      sc_a = 1'b0; sc_b = 1'b0; sc_z = 1'b0;

      // Leaf truth table indexed by {a,b,z}: only 110 and 001 overflow.
      sc_table = 8'b0100_0010;
      for (int i = 0; i < 8; i++) begin
         {sc_a, sc_b, sc_z} = 3'(i);
         #10;
         chk($sformatf("sign_check%0d", i), 32'(sc_ovf), 32'(sc_table[i]));
      end

      repeat (2) @(posedge clk);
      #1;
      chk_res("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      @(negedge clk);
      rst = 1'b0;

      apply(8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);
      chk_res("add_7f_01", 8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1);
      apply(8'h05, 8'h03, 1'b0, 1'b1, 1'b0);
      chk_res("add_05_03", 8'h08, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
      apply(8'h80, 8'hFF, 1'b0, 1'b1, 1'b0);
      chk_res("add_80_ff", 8'h7F, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
      apply(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
      chk_res("sub_80_01", 8'h7F, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
      apply(8'h00, 8'h80, 1'b1, 1'b1, 1'b0);
      chk_res("sub_00_80", 8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3);
      apply(8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
      chk_res("sub_80_80", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3);
      apply(8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);
      chk_res("sat_5th", 8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3);

      apply(8'h05, 8'h03, 1'b0, 1'b1, 1'b0);
      chk_res("pre_gate", 8'h08, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3);
      apply(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
      chk_res("gated", 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);

      apply(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1);
      chk_res("clr_wins", 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
      apply(8'h80, 8'hFF, 1'b0, 1'b1, 1'b0);
      chk_res("after_clr", 8'h7F, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1);

      apply(8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);
      chk_res("pre_rst", 8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2);
      #2;
      rst = 1'b1;
      #1;
      chk_res("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      @(posedge clk);
      #1;
      chk_res("rst_held", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      @(negedge clk);
      rst = 1'b0;
      apply(8'h05, 8'h03, 1'b0, 1'b1, 1'b0);
      chk_res("post_rst", 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
